// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single MMU port between the IF fetch requester and the MEM-stage
// load/store requester. A granted request is held on the MMU until
// mmu_mem_ready. The response then goes back to the winner as a one-cycle
// valid pulse. Fetches killed by if_flush while in flight are dropped.
//
// Optional feature: define MEM_ARB_FAIRNESS_EN to add a starvation guard.
// After STARVE_LIMIT back-to-back data grants with a fetch waiting, the fetch
// wins once. With the macro undefined, data always has priority.
//
// State table:
//   IDLE | arbitrate; latch the winner's request into the MMU registers
//   WAIT | MMU access in flight; enables asserted, request held stable
//   RESP | one-cycle valid pulse to the owner; always returns to IDLE

`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'b00
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'b01
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'b10
`endif

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_signed,
    input  logic [1:0]  dm_width,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    input  logic        mmu_mem_ready,
    input  logic [31:0] mmu_data_out,
    output logic        mmu_read_enable,
    output logic        mmu_write_enable,
    output logic        mmu_mem_signed_read,
    output logic [1:0]  mmu_mem_data_width,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state;
    logic   owner_fetch;
    logic   discard;
    logic   disc_next;
    logic   fetch_ok;
    logic   starve;
    logic   grant_dm;
    logic   grant_if;

    assign fetch_ok  = if_req & ~if_flush;
    assign disc_next = discard | (if_flush & owner_fetch);

    // Stall outputs follow the request until its valid pulse.
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [2:0] streak;

    assign starve = (streak >= 3'(STARVE_LIMIT)) & dm_req & fetch_ok;

    // Count consecutive data grants taken while a fetch was waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= 3'd0;
        end else if (grant_if) begin
            streak <= 3'd0;
        end else if (grant_dm) begin
            if (!if_req)
                streak <= 3'd0;
            else if (streak != 3'd7)
                streak <= streak + 3'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Arbitration decision, only meaningful in IDLE.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            if (dm_req && !starve)
                grant_dm = 1'b1;
            else if (fetch_ok)
                grant_if = 1'b1;
        end
    end

    // Main FSM with registered MMU and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            owner_fetch         <= 1'b1;
            discard             <= 1'b0;
            if_valid            <= 1'b0;
            if_rdata            <= 32'd0;
            dm_valid            <= 1'b0;
            dm_rdata            <= 32'd0;
            mmu_read_enable     <= 1'b0;
            mmu_write_enable    <= 1'b0;
            mmu_mem_signed_read <= 1'b0;
            mmu_mem_data_width  <= 2'b00;
            mmu_address         <= 32'd0;
            mmu_data_in         <= 32'd0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (grant_dm) begin
                        owner_fetch         <= 1'b0;
                        mmu_address         <= dm_addr;
                        mmu_data_in         <= dm_wdata;
                        mmu_mem_data_width  <= dm_width;
                        mmu_mem_signed_read <= dm_signed;
                        mmu_write_enable    <= dm_we;
                        mmu_read_enable     <= ~dm_we;
                        state               <= WAIT;
                    end else if (grant_if) begin
                        owner_fetch         <= 1'b1;
                        mmu_address         <= if_addr;
                        mmu_data_in         <= 32'd0;
                        mmu_mem_data_width  <= `MMU_WIDTH_WORD;
                        mmu_mem_signed_read <= 1'b0;
                        mmu_write_enable    <= 1'b0;
                        mmu_read_enable     <= 1'b1;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    // A flush landing in the same cycle as ready still discards.
                    discard <= disc_next;
                    if (mmu_mem_ready) begin
                        mmu_read_enable  <= 1'b0;
                        mmu_write_enable <= 1'b0;
                        state            <= RESP;
                        if (owner_fetch) begin
                            if (!disc_next) begin
                                if_valid <= 1'b1;
                                if_rdata <= mmu_data_out;
                            end
                        end else begin
                            dm_valid <= 1'b1;
                            dm_rdata <= mmu_data_out;
                        end
                    end
                end
                RESP: begin
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
